// File: rtl/dmem_responder_if.sv
// Request/response bus between a data-memory initiator and dmem_responder.
// Signal names carry the responder's point of view (_i driven by the initiator).
interface dmem_responder_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [3:0]  req_be_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;

    // A transfer happens on a rising edge where valid && ready; the sender
    // holds its payload stable from raising valid until that edge.
    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: 32-bit word array with byte-enable
// stores, fixed request-to-response latency and misalignment/range errors.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic            clk,
    input  logic            rst,
    dmem_responder_if.slave bus,
    output logic [1:0]      dbg_state_o
);
    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        alive_q, alive_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH_WORDS] = '{default: 32'h0};

    logic          req_ready;
    logic          req_fire;
    logic          enter_resp;
    logic          cur_we;
    logic [31:0]   cur_addr;
    logic [31:0]   cur_wdata;
    logic [3:0]    cur_be;
    logic          cur_err;
    logic [AW-1:0] word_idx;
    logic          mem_we;

    assign req_fire   = bus.req_valid_i && req_ready;
    assign enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);

    // With LATENCY = 1 the response is formed on the acceptance edge itself,
    // before the capture registers hold the request, so take the live inputs.
    assign cur_we    = req_fire ? bus.req_we_i    : we_q;
    assign cur_addr  = req_fire ? bus.req_addr_i  : addr_q;
    assign cur_wdata = req_fire ? bus.req_wdata_i : wdata_q;
    assign cur_be    = req_fire ? bus.req_be_i    : be_q;

    assign cur_err  = (cur_addr[1:0] != 2'b00) ||
                      ({2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS));
    assign word_idx = cur_addr[AW+1:2];
    assign mem_we   = enter_resp && cur_we && !cur_err && rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (req_fire) state_d = (LATENCY > 1) ? ST_WAIT : ST_RESP;
            ST_WAIT: if (cnt_q == 4'd0) state_d = ST_RESP;
            ST_RESP: if (bus.rsp_ready_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready       = (state_q == ST_IDLE) && alive_q;
        bus.req_ready_o = req_ready;
        bus.rsp_valid_o = (state_q == ST_RESP);
        bus.rsp_rdata_o = rdata_q;
        bus.rsp_err_o   = err_q;
        dbg_state_o     = state_q;
    end

    always_comb begin
        alive_d = 1'b1;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        if (req_fire) begin
            we_d    = bus.req_we_i;
            addr_d  = bus.req_addr_i;
            wdata_d = bus.req_wdata_i;
            be_d    = bus.req_be_i;
            cnt_d   = WAIT_LOAD;
        end else if ((state_q == ST_WAIT) && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
        // Load data is the word as it stands on the edge that enters RESP.
        if (enter_resp) begin
            err_d   = cur_err;
            rdata_d = (cur_err || cur_we) ? 32'h0 : mem_q[word_idx];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= 4'd0;
            alive_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            be_q    <= 4'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            alive_q <= alive_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // The array is never reset; a store lands on the edge that enters RESP.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int n = 0; n < 4; n++) begin
                if (cur_be[n]) mem_q[word_idx][8*n +: 8] <= cur_wdata[8*n +: 8];
            end
        end
    end
endmodule
